led_blink_driver: RTL and testbench

Output-side counterpart to the button debouncer. It takes clean, single-cycle blink requests from core logic over a valid/ready handshake and drives one board LED through timed on/off blink sequences. It holds one pending request while a sequence is playing, so events arriving back-to-back are not lost.

---
 rtl/led_blink_driver_if.sv | 21 ++
 rtl/led_blink_driver.sv | 163 ++++++++++++++++
 tb/tb_led_blink_driver.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_blink_driver_if.sv
// Request channel into the LED blink driver: a valid/ready handshake
// carrying the number of blinks to play.
interface led_blink_driver_if;
  logic       req_valid;
  logic [3:0] req_count;
  logic       req_ready;

  // Core logic issuing blink requests.
  modport master (
    output req_valid,
    output req_count,
    input  req_ready
  );

  // The blink driver accepting requests.
  modport slave (
    input  req_valid,
    input  req_count,
    output req_ready
  );
endinterface

// File: rtl/led_blink_driver.sv
// LED blink driver: plays req_count on/off blinks on one board LED.
// One sequence plays at a time; a single pending slot holds the next
// request so back-to-back events chain with no idle cycle in between.
module led_blink_driver #(
  parameter int unsigned ON_TICKS       = 8,
  parameter int unsigned OFF_TICKS      = 8,
  parameter int unsigned CNT_W          = 16,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  led_blink_driver_if.slave req,
  output logic              led,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  // Phase counter reload values; the counter runs N-1 down to 0, so each
  // phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Pin levels for a lit and a dark LED.
  localparam logic LED_LIT  = !LED_ACTIVE_LOW;
  localparam logic LED_DARK = LED_ACTIVE_LOW;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       blinks_q, blinks_d;
  logic             pend_vld_q, pend_vld_d;
  logic [3:0]       pend_cnt_q, pend_cnt_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer;
  logic             req_nz;
  logic             cnt_zero;
  logic             seq_end;

  // A transfer happens whenever the pending slot is free; a zero count
  // is swallowed by the handshake but never starts or queues anything.
  assign req.req_ready = !pend_vld_q;
  assign xfer          = req.req_valid && !pend_vld_q;
  assign req_nz        = xfer && (req.req_count != 4'd0);
  assign cnt_zero      = (cnt_q == '0);

  // Last cycle of the last OFF phase of the active sequence.
  assign seq_end       = (state_q == ST_OFF) && cnt_zero && (blinks_q == 4'd1);

  // Next-state logic: phase sequencing, sequence chaining and pending slot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blinks_d   = blinks_q;
    pend_vld_d = pend_vld_q;
    pend_cnt_d = pend_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_nz) begin
          state_d  = ST_ON;
          cnt_d    = ON_LOAD;
          blinks_d = req.req_count;
        end
      end

      ST_ON: begin
        if (cnt_zero) begin
          state_d = ST_OFF;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_OFF: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!seq_end) begin
          // Another blink of the same sequence follows.
          state_d  = ST_ON;
          cnt_d    = ON_LOAD;
          blinks_d = blinks_q - 4'd1;
        end else begin
          // Sequence finished: the queued request wins over a request
          // arriving on this very edge (the latter cannot transfer while
          // the slot is full anyway), otherwise fall back to idle.
          done_d = 1'b1;
          if (pend_vld_q) begin
            state_d    = ST_ON;
            cnt_d      = ON_LOAD;
            blinks_d   = pend_cnt_q;
            pend_vld_d = 1'b0;
          end else if (req_nz) begin
            state_d  = ST_ON;
            cnt_d    = ON_LOAD;
            blinks_d = req.req_count;
          end else begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            blinks_d = 4'd0;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        blinks_d = 4'd0;
      end
    endcase

    // A request arriving mid-sequence is parked until the sequence ends.
    if (req_nz && (state_q != ST_IDLE) && !seq_end) begin
      pend_vld_d = 1'b1;
      pend_cnt_d = req.req_count;
    end
  end

  // Output decode from the next state so led/busy/done are registered
  // and line up with the state they describe.
  always_comb begin
    led_d  = (state_d == ST_ON) ? LED_LIT : LED_DARK;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any active or queued work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      blinks_q   <= 4'd0;
      pend_vld_q <= 1'b0;
      pend_cnt_q <= 4'd0;
      led_q      <= LED_DARK;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blinks_q   <= blinks_d;
      pend_vld_q <= pend_vld_d;
      pend_cnt_q <= pend_cnt_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: directed scenarios on an active-high and an
// active-low instance, plus a long randomized run against a timeline model.
module tb_led_blink_driver;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int PER = ON + OFF;

  logic clk = 1'b0;
  logic rst;
  logic led_a, busy_a, done_a;
  logic led_b, busy_b, done_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  led_blink_driver_if bus_a ();
  led_blink_driver_if bus_b ();

  led_blink_driver #(
    .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(8), .LED_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .req(bus_a), .led(led_a), .busy(busy_a), .done(done_a)
  );

  led_blink_driver #(
    .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(8), .LED_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .req(bus_b), .led(led_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Reset between edges while a sequence is lit on both instances.
  task automatic test_reset();
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd2;
    bus_b.req_valid = 1'b1; bus_b.req_count = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0; bus_b.req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (led_a !== 1'b1) $display("FAIL reset_pre_led got=%b exp=1", led_a); else pass_cnt++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({led_a, busy_a, done_a, bus_a.req_ready} !== 4'b0001)
      $display("FAIL reset_a led/busy/done/ready got=%b exp=0001", {led_a, busy_a, done_a, bus_a.req_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({led_b, busy_b, done_b, bus_b.req_ready} !== 4'b1001)
      $display("FAIL reset_b led/busy/done/ready got=%b exp=1001", {led_b, busy_b, done_b, bus_b.req_ready});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request of two blinks from idle.
  task automatic test_single();
    logic [1:12] e_led, e_busy, e_done;
    e_led  = 12'b111001110000;
    e_busy = 12'b111111111100;
    e_done = 12'b000000000010;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd2;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({led_a, busy_a, done_a} !== {e_led[k], e_busy[k], e_done[k]})
        $display("FAIL single cyc=%0d led/busy/done got=%b exp=%b", k,
                 {led_a, busy_a, done_a}, {e_led[k], e_busy[k], e_done[k]});
      else pass_cnt++;
      if (k == 1) bus_a.req_valid = 1'b0;
    end
  endtask

  // A at edge 0, B at edge 2 (queued), C offered from cycle 3 onward.
  task automatic test_back_to_back();
    logic [1:17] e_led, e_busy, e_done, e_rdy;
    e_led  = 17'b11100111001110000;
    e_busy = 17'b11111111111111100;
    e_done = 17'b00000100001000010;
    e_rdy  = 17'b11000100001111111;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd1;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({led_a, busy_a, done_a, bus_a.req_ready} !== {e_led[k], e_busy[k], e_done[k], e_rdy[k]})
        $display("FAIL b2b cyc=%0d led/busy/done/ready got=%b exp=%b", k,
                 {led_a, busy_a, done_a, bus_a.req_ready}, {e_led[k], e_busy[k], e_done[k], e_rdy[k]});
      else pass_cnt++;
      if (k == 1) bus_a.req_valid = 1'b0;
      if (k == 2) begin bus_a.req_valid = 1'b1; bus_a.req_count = 4'd1; end
      if (k == 7) bus_a.req_valid = 1'b0;
    end
  endtask

  // A zero-count request is accepted and has no visible effect.
  task automatic test_null();
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd0;
    chk_cnt++;
    if (bus_a.req_ready !== 1'b1) $display("FAIL null_ready got=%b exp=1", bus_a.req_ready); else pass_cnt++;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.req_valid = 1'b0;
      chk_cnt++;
      if ({led_a, busy_a, done_a, bus_a.req_ready} !== 4'b0001)
        $display("FAIL null cyc=%0d led/busy/done/ready got=%b exp=0001", k, {led_a, busy_a, done_a, bus_a.req_ready});
      else pass_cnt++;
    end
  endtask

  // Reset in cycle 4 of a 3-blink sequence with a 2-blink request queued.
  task automatic test_reset_mid();
    logic [1:7] e_led, e_busy, e_done;
    e_led  = 7'b1110000;
    e_busy = 7'b1111100;
    e_done = 7'b0000010;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_count = 4'd2;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    chk_cnt++;
    if ({busy_a, bus_a.req_ready} !== 2'b10)
      $display("FAIL rmid_queued busy/ready got=%b exp=10", {busy_a, bus_a.req_ready});
    else pass_cnt++;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({led_a, busy_a, done_a, bus_a.req_ready} !== 4'b0001)
      $display("FAIL rmid_reset led/busy/done/ready got=%b exp=0001", {led_a, busy_a, done_a, bus_a.req_ready});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_cnt++;
      if ({led_a, busy_a, done_a} !== 3'b000)
        $display("FAIL rmid_quiet cyc=%0d led/busy/done got=%b exp=000", k, {led_a, busy_a, done_a});
      else pass_cnt++;
    end
    bus_a.req_valid = 1'b1; bus_a.req_count = 4'd1;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus_a.req_valid = 1'b0;
      chk_cnt++;
      if ({led_a, busy_a, done_a} !== {e_led[k], e_busy[k], e_done[k]})
        $display("FAIL rmid_after cyc=%0d led/busy/done got=%b exp=%b", k,
                 {led_a, busy_a, done_a}, {e_led[k], e_busy[k], e_done[k]});
      else pass_cnt++;
    end
  endtask

  // Active-low instance: one blink.
  task automatic test_polarity();
    logic [1:10] e_led, e_busy, e_done;
    e_led  = 10'b0001111111;
    e_busy = 10'b1111100000;
    e_done = 10'b0000010000;
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_count = 4'd1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus_b.req_valid = 1'b0;
      chk_cnt++;
      if ({led_b, busy_b, done_b} !== {e_led[k], e_busy[k], e_done[k]})
        $display("FAIL polarity cyc=%0d led/busy/done got=%b exp=%b", k,
                 {led_b, busy_b, done_b}, {e_led[k], e_busy[k], e_done[k]});
      else pass_cnt++;
    end
  endtask

  // Random requests checked against a timeline of sequences: each
  // sequence is a start edge s and a last lit/dark cycle e = s + N*PER.
  task automatic test_random();
    int  m_s, m_e, m_done, m_pc, cnt;
    bit  m_pv, hold, xfer;
    logic el, eb, ed, er;
    @(negedge clk);
    rst = 1'b1;
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_s = -10; m_e = -10; m_done = -10; m_pv = 1'b0; m_pc = 0; hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      eb = (c > m_s) && (c <= m_e);
      el = eb && (((c - m_s - 1) % PER) < ON);
      ed = (c == m_done);
      er = !m_pv;
      chk_cnt++;
      if ({led_a, busy_a, done_a, bus_a.req_ready} !== {el, eb, ed, er})
        $display("FAIL random cyc=%0d led/busy/done/ready got=%b exp=%b", c,
                 {led_a, busy_a, done_a, bus_a.req_ready}, {el, eb, ed, er});
      else pass_cnt++;
      if (!hold) begin
        bus_a.req_valid = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) bus_a.req_count = 4'($urandom_range(0, 15));
        else                           bus_a.req_count = 4'($urandom_range(0, 3));
      end
      cnt  = int'(bus_a.req_count);
      xfer = bus_a.req_valid && !m_pv;
      hold = bus_a.req_valid && !xfer;
      if (c == m_e) begin
        m_done = c + 1;
        if (m_pv) begin
          m_s = c; m_e = c + m_pc * PER; m_pv = 1'b0;
        end else if (xfer && cnt != 0) begin
          m_s = c; m_e = c + cnt * PER;
        end
      end else if (c > m_s && c < m_e) begin
        if (xfer && cnt != 0) begin m_pv = 1'b1; m_pc = cnt; end
      end else if (xfer && cnt != 0) begin
        m_s = c; m_e = c + cnt * PER;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus_a.req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_count = 4'd0;
    bus_b.req_valid = 1'b0; bus_b.req_count = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_null();
    test_reset_mid();
    test_polarity();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
